riscv_csr_unit: RTL and testbench
=================================

# riscv_csr_unit

Machine-mode CSR responder for the 5-stage `riscv_core`. It answers the core's CSR read and write requests, records exceptions (ecall, ebreak, instruction/load/store misalignment), and redirects fetch to the trap vector or to `mepc` on `mret`. While it redirects, it stalls fetch with `csr_delay`. It sits beside the core at top level and owns all M-mode architectural state.

## Interface
- `IRQ`, 0 — external interrupts are not supported when 0; `mip` reads 0 and `mie` is storage only.
- `MHARTID`, 0 — value returned by `mhartid`.
- `clk` in 1 — the only clock.
- `reset` in 1 — asynchronous, active-low reset.
- `csr_rd_en` in 1 — read request.
- `csr_rd_addr` in 12 — read address.
- `csr_rd_data` out 32 — registered read data.
- `csr_wr_en` in 1 — write request.
- `csr_wr_addr` in 12 — write address.
- `csr_wr_data` in 32 — write data; already merged for CSRRS/CSRRC by the core.
- `pc` in 32 — PC of the excepting or `mret` instruction; becomes `mepc`.
- `pc_addr_in` in 32 — branch target; becomes `mtval` on `i_misalign`.
- `mem_addr` in 32 — data address; becomes `mtval` on `l_misalign`/`s_misalign`.
- `ecall`, `ebreak`, `mret`, `i_misalign`, `l_misalign`, `s_misalign` in 1 each — single-cycle event pulses.
- `csr_delay` out 1 — fetch stall while a redirect is in progress.
- `pc_csr` out 32 — redirect target, valid while `csr_delay`=1.

## Operation
- Implemented CSRs:
  - `mstatus` 0x300: MIE bit 3 and MPIE bit 7 are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - `misa` 0x301: reads 0x40000100; read-only.
  - `mie` 0x304: writable.
  - `mtvec` 0x305: direct mode; bits [1:0] are forced to 0.
  - `mscratch` 0x340: writable.
  - `mepc` 0x341: bits [1:0] are forced to 0.
  - `mcause` 0x342, `mtval` 0x343: writable.
  - `mip` 0x344: reads 0.
  - `mcycle` 0xB00, `mcycleh` 0xB80: writable.
  - `mhartid` 0xF14: read-only.
- Reads of unimplemented addresses return 0.
- Writes to read-only or unimplemented addresses are ignored.
- `mcycle`/`mcycleh` form one 64-bit counter that increments every cycle. A write to either half replaces that half for the cycle; the increment is skipped in that cycle.
- FSM states: IDLE, SAVE, JUMP, RET.
  - IDLE → SAVE on any exception pulse.
  - IDLE → RET on `mret` when no exception pulse is present.
  - SAVE → JUMP.
  - JUMP → IDLE.
  - RET → IDLE.
- Exceptions are latched in IDLE only; event pulses in other states are ignored.
- Exception priority and codes:
  - `i_misalign`: `mcause`=0, `mtval`=`pc_addr_in`.
  - `l_misalign`: `mcause`=4, `mtval`=`mem_addr`.
  - `s_misalign`: `mcause`=6, `mtval`=`mem_addr`.
  - `ecall`: `mcause`=11, `mtval`=0.
  - `ebreak`: `mcause`=3, `mtval`=`pc`.
  - `mret`: lowest priority.
- On IDLE→SAVE, cause, `pc` and the `mtval` source are captured. At the end of SAVE:
  - `mepc` ← captured `pc`.
  - `mcause` and `mtval` are written.
  - MPIE ← MIE; MIE ← 0.
- At the end of RET: MIE ← MPIE; MPIE ← 1.
- A CSR write in the same cycle as a trap-side update to the same register loses; the trap update wins.

## Timing
- Reset values:
  - `csr_rd_data`=0, `csr_delay`=0, `pc_csr`=0, state=IDLE.
  - All writable CSRs are 0; the counter is 0.
- Read latency is 1 cycle: `csr_rd_en` at edge N gives `csr_rd_data` valid after edge N+1. The output holds its value when `csr_rd_en`=0.
- A write takes effect at the edge where `csr_wr_en`=1. A read of the same address issued in that cycle returns the old value.
- Exception pulse in cycle N:
  - `csr_delay`=1 in cycles N+1 and N+2.
  - `pc_csr`=`mtvec` in cycle N+2.
  - Back in IDLE at N+3.
- `mret` in cycle N: `csr_delay`=1 and `pc_csr`=`mepc` in cycle N+1 only.
- `csr_delay` and `pc_csr` are registered, driven from state; `pc_csr` is 0 while in IDLE.
- Reset asserted mid-trap returns to IDLE immediately. Partially captured cause/PC are discarded.

## Structure
- Package `riscv_csr_pkg` holds:
  - CSR address localparams.
  - Cause-code localparams.
  - The `misa` constant.
  - The `csr_state_t` enum (IDLE/SAVE/JUMP/RET).
- Sub-module `riscv_csr_counter`: a 64-bit free-running counter with per-half write ports.

## Test plan
- Reset: release reset, read 0x300, 0x305, 0x301 → 0x00001800, 0x0, 0x40000100.
- Write/read: write `mtvec` 0x00000103, then read → 0x00000100. Write `misa` 0x0, then read → 0x40000100.
- `ecall` trap: `mtvec`=0x80, MIE=1, `pc`=0x44, pulse `ecall` →
  - `csr_delay` high for 2 cycles; `pc_csr`=0x80 on the second.
  - `mepc`=0x44, `mcause`=11, `mstatus`=0x1880.
- `mret`: after the previous test, pulse `mret` → one cycle with `pc_csr`=0x44; then `mstatus`=0x1888.
- Priority and masking:
  - Simultaneous `l_misalign`+`ecall` with `mem_addr`=0x1003 → `mcause`=4, `mtval`=0x1003.
  - A second `ebreak` during SAVE is ignored.
- Counter: write `mcycle`=0xFFFFFFFF, idle 2 cycles → `mcycleh`=1, `mcycle`=1.

Source files
------------

// File: rtl/riscv_csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, trap cause
// codes, the misa constant and the trap sequencer state type.
package riscv_csr_pkg;

  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMisa     = 12'h301;
  localparam logic [11:0] CsrMie      = 12'h304;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;
  localparam logic [11:0] CsrMtval    = 12'h343;
  localparam logic [11:0] CsrMip      = 12'h344;
  localparam logic [11:0] CsrMcycle   = 12'hB00;
  localparam logic [11:0] CsrMcycleh  = 12'hB80;
  localparam logic [11:0] CsrMhartid  = 12'hF14;

  localparam logic [31:0] CauseIMisalign = 32'd0;
  localparam logic [31:0] CauseEbreak    = 32'd3;
  localparam logic [31:0] CauseLMisalign = 32'd4;
  localparam logic [31:0] CauseSMisalign = 32'd6;
  localparam logic [31:0] CauseEcall     = 32'd11;

  // RV32I base ISA
  localparam logic [31:0] MisaValue = 32'h4000_0100;

  typedef enum logic [1:0] {
    StIdle,
    StSave,
    StJump,
    StRet
  } csr_state_t;

endpackage

// File: rtl/riscv_csr_if.sv
// Core <-> CSR unit connection: CSR read/write port, trap event pulses and
// their context (pc, branch target, data address), and the fetch redirect.
//   master : the core (drives requests and events, receives data and redirect)
//   slave  : the CSR unit
interface riscv_csr_if;
  logic        csr_rd_en;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic [31:0] pc;
  logic [31:0] pc_addr_in;
  logic [31:0] mem_addr;
  logic        ecall;
  logic        ebreak;
  logic        mret;
  logic        i_misalign;
  logic        l_misalign;
  logic        s_misalign;
  logic        csr_delay;
  logic [31:0] pc_csr;

  modport master (
    output csr_rd_en, csr_rd_addr, csr_wr_en, csr_wr_addr, csr_wr_data,
    output pc, pc_addr_in, mem_addr,
    output ecall, ebreak, mret, i_misalign, l_misalign, s_misalign,
    input  csr_rd_data, csr_delay, pc_csr
  );

  modport slave (
    input  csr_rd_en, csr_rd_addr, csr_wr_en, csr_wr_addr, csr_wr_data,
    input  pc, pc_addr_in, mem_addr,
    input  ecall, ebreak, mret, i_misalign, l_misalign, s_misalign,
    output csr_rd_data, csr_delay, pc_csr
  );
endinterface

// File: rtl/riscv_csr_counter.sv
// 64-bit free-running cycle counter with independent write ports for the low
// and high halves. A write to either half suppresses the increment that cycle.
//   clk, reset : clock, asynchronous active-low reset
//   wr_lo_i    : replace bits [31:0] with wr_data_i
//   wr_hi_i    : replace bits [63:32] with wr_data_i
//   count_o    : current counter value
module riscv_csr_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wr_data_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 64'd1;
    if (wr_lo_i || wr_hi_i) begin
      count_d = count_q;
      if (wr_lo_i) count_d[31:0]  = wr_data_i;
      if (wr_hi_i) count_d[63:32] = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/riscv_csr_unit.sv
// Machine-mode CSR responder. Serves registered CSR reads and writes, records
// exceptions and redirects fetch to mtvec (trap) or mepc (mret), holding
// csr_delay high while the redirect is in progress.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : riscv_csr_if slave port (CSR port, events, redirect)
// Parameters: IRQ (0: no interrupt sources, mip reads 0), MHARTID.
module riscv_csr_unit import riscv_csr_pkg::*; #(
  parameter int unsigned IRQ     = 0,
  parameter logic [31:0] MHARTID = 32'h0
) (
  input  logic       clk,
  input  logic       reset,
  riscv_csr_if.slave bus
);

  csr_state_t  state_q, state_d;
  logic        status_mie_q, status_mie_d;
  logic        status_mpie_q, status_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  // Trap context captured on entry to StSave
  logic [31:0] cap_cause_q, cap_cause_d;
  logic [31:0] cap_pc_q, cap_pc_d;
  logic [31:0] cap_tval_q, cap_tval_d;
  logic        delay_q, delay_d;
  logic [31:0] pc_csr_q, pc_csr_d;
  logic [31:0] rd_data_q, rdata;
  logic [63:0] cycle;
  logic        any_exc;

  assign any_exc = bus.i_misalign | bus.l_misalign | bus.s_misalign | bus.ecall | bus.ebreak;

  riscv_csr_counter u_counter (
    .clk       (clk),
    .reset     (reset),
    .wr_lo_i   (bus.csr_wr_en && (bus.csr_wr_addr == CsrMcycle)),
    .wr_hi_i   (bus.csr_wr_en && (bus.csr_wr_addr == CsrMcycleh)),
    .wr_data_i (bus.csr_wr_data),
    .count_o   (cycle)
  );

  // Trap sequencer
  always_comb begin
    state_d     = state_q;
    cap_cause_d = cap_cause_q;
    cap_pc_d    = cap_pc_q;
    cap_tval_d  = cap_tval_q;
    unique case (state_q)
      StIdle: begin
        if (any_exc) begin
          state_d  = StSave;
          cap_pc_d = bus.pc;
          if (bus.i_misalign) begin
            cap_cause_d = CauseIMisalign;
            cap_tval_d  = bus.pc_addr_in;
          end else if (bus.l_misalign) begin
            cap_cause_d = CauseLMisalign;
            cap_tval_d  = bus.mem_addr;
          end else if (bus.s_misalign) begin
            cap_cause_d = CauseSMisalign;
            cap_tval_d  = bus.mem_addr;
          end else if (bus.ecall) begin
            cap_cause_d = CauseEcall;
            cap_tval_d  = '0;
          end else begin
            cap_cause_d = CauseEbreak;
            cap_tval_d  = bus.pc;
          end
        end else if (bus.mret) begin
          state_d = StRet;
        end
      end
      StSave:  state_d = StJump;
      StJump:  state_d = StIdle;
      StRet:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Redirect outputs are registered from the upcoming state
    delay_d  = (state_d != StIdle);
    pc_csr_d = '0;
    if (state_d == StJump)     pc_csr_d = mtvec_q;
    else if (state_d == StRet) pc_csr_d = mepc_q;
  end

  // CSR writes, then trap-side updates which take precedence
  always_comb begin
    status_mie_d  = status_mie_q;
    status_mpie_d = status_mpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    if (bus.csr_wr_en) begin
      case (bus.csr_wr_addr)
        CsrMstatus: begin
          status_mie_d  = bus.csr_wr_data[3];
          status_mpie_d = bus.csr_wr_data[7];
        end
        CsrMie:      mie_d      = bus.csr_wr_data;
        CsrMtvec:    mtvec_d    = {bus.csr_wr_data[31:2], 2'b00};
        CsrMscratch: mscratch_d = bus.csr_wr_data;
        CsrMepc:     mepc_d     = {bus.csr_wr_data[31:2], 2'b00};
        CsrMcause:   mcause_d   = bus.csr_wr_data;
        CsrMtval:    mtval_d    = bus.csr_wr_data;
        default: ;
      endcase
    end
    if (state_q == StSave) begin
      mepc_d        = {cap_pc_q[31:2], 2'b00};
      mcause_d      = cap_cause_q;
      mtval_d       = cap_tval_q;
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
    end else if (state_q == StRet) begin
      status_mie_d  = status_mpie_q;
      status_mpie_d = 1'b1;
    end
  end

  // Read mux over the current (pre-write) state
  always_comb begin
    rdata = '0;
    case (bus.csr_rd_addr)
      CsrMstatus:  rdata = {19'b0, 2'b11, 3'b0, status_mpie_q, 3'b0, status_mie_q, 3'b0};
      CsrMisa:     rdata = MisaValue;
      CsrMie:      rdata = mie_q;
      CsrMtvec:    rdata = mtvec_q;
      CsrMscratch: rdata = mscratch_q;
      CsrMepc:     rdata = mepc_q;
      CsrMcause:   rdata = mcause_q;
      CsrMtval:    rdata = mtval_q;
      // No interrupt sources are wired, so nothing is ever pending
      CsrMip:      if (IRQ == 0) rdata = '0;
      CsrMcycle:   rdata = cycle[31:0];
      CsrMcycleh:  rdata = cycle[63:32];
      CsrMhartid:  rdata = MHARTID;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      status_mie_q  <= 1'b0;
      status_mpie_q <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= '0;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      cap_cause_q   <= '0;
      cap_pc_q      <= '0;
      cap_tval_q    <= '0;
      delay_q       <= 1'b0;
      pc_csr_q      <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      status_mie_q  <= status_mie_d;
      status_mpie_q <= status_mpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      cap_cause_q   <= cap_cause_d;
      cap_pc_q      <= cap_pc_d;
      cap_tval_q    <= cap_tval_d;
      delay_q       <= delay_d;
      pc_csr_q      <= pc_csr_d;
      if (bus.csr_rd_en) rd_data_q <= rdata;
    end
  end

  assign bus.csr_rd_data = rd_data_q;
  assign bus.csr_delay   = delay_q;
  assign bus.pc_csr      = pc_csr_q;

endmodule

// File: tb/tb_riscv_csr_unit.sv
// Testbench for riscv_csr_unit: directed stimulus, an event-timeline model of
// the CSR file checked every cycle, and literal expectations for key results.
module tb_riscv_csr_unit;

  logic clk;
  logic reset;
  riscv_csr_if bus ();

  riscv_csr_unit #(
    .IRQ     (0),
    .MHARTID (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic        m_live = 1'b0;
  logic        m_st_mie, m_st_mpie;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cnt;
  logic [31:0] cap_cause, cap_pc, cap_tval;
  int          ecount, trap_end, ret_end, ign_until;
  logic [31:0] e_rd, e_pc;
  logic        e_delay;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_st_mpie) << 7) | (32'(m_st_mie) << 3);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00: return m_cnt[31:0];
      12'hB80: return m_cnt[63:32];
      default: return 32'h0;  // includes mip, mhartid (0) and unimplemented
    endcase
  endfunction

  task automatic m_reset();
    m_st_mie = 0; m_st_mpie = 0; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cnt = 0;
    ecount = 0; trap_end = -1; ret_end = -1; ign_until = -1;
    e_rd = 0; e_pc = 0; e_delay = 0;
    m_live = 1'b1;
  endtask

  task automatic m_edge();
    logic [31:0] pre_mtvec, pre_mepc, d;
    logic        pre_mie, pre_mpie;
    logic [11:0] a;
    ecount++;
    pre_mtvec = m_mtvec; pre_mepc = m_mepc;
    pre_mie = m_st_mie;  pre_mpie = m_st_mpie;
    if (bus.csr_rd_en) e_rd = m_read(bus.csr_rd_addr);
    a = bus.csr_wr_addr;
    d = bus.csr_wr_data;
    if (bus.csr_wr_en && a == 12'hB00)      m_cnt[31:0]  = d;
    else if (bus.csr_wr_en && a == 12'hB80) m_cnt[63:32] = d;
    else                                    m_cnt = m_cnt + 64'd1;
    if (bus.csr_wr_en) begin
      case (a)
        12'h300: begin m_st_mie = d[3]; m_st_mpie = d[7]; end
        12'h304: m_mie = d;
        12'h305: m_mtvec = d & ~32'h3;
        12'h340: m_mscratch = d;
        12'h341: m_mepc = d & ~32'h3;
        12'h342: m_mcause = d;
        12'h343: m_mtval = d;
        default: ;
      endcase
    end
    e_delay = 1'b0;
    e_pc    = 32'h0;
    if (ecount == trap_end) begin
      m_mepc = cap_pc & ~32'h3; m_mcause = cap_cause; m_mtval = cap_tval;
      m_st_mpie = pre_mie; m_st_mie = 1'b0;
      e_delay = 1'b1; e_pc = pre_mtvec;
    end
    if (ecount == ret_end) begin
      m_st_mie = pre_mpie; m_st_mpie = 1'b1;
    end
    if (ecount > ign_until) begin
      if (bus.i_misalign | bus.l_misalign | bus.s_misalign | bus.ecall | bus.ebreak) begin
        cap_pc = bus.pc;
        if (bus.i_misalign)      begin cap_cause = 0;  cap_tval = bus.pc_addr_in; end
        else if (bus.l_misalign) begin cap_cause = 4;  cap_tval = bus.mem_addr; end
        else if (bus.s_misalign) begin cap_cause = 6;  cap_tval = bus.mem_addr; end
        else if (bus.ecall)      begin cap_cause = 11; cap_tval = 0; end
        else                     begin cap_cause = 3;  cap_tval = bus.pc; end
        trap_end = ecount + 1; ign_until = ecount + 2; e_delay = 1'b1;
      end else if (bus.mret) begin
        ret_end = ecount + 1; ign_until = ecount + 1;
        e_delay = 1'b1; e_pc = pre_mepc;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) m_reset();
    else        m_edge();
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (reset === 1'b1 && m_live) begin
      chk("cyc_rd_data", bus.csr_rd_data, e_rd);
      chk("cyc_csr_delay", {31'b0, bus.csr_delay}, {31'b0, e_delay});
      chk("cyc_pc_csr", bus.pc_csr, e_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    bus.csr_wr_en = 1'b1; bus.csr_wr_addr = a; bus.csr_wr_data = d;
    tick();
    bus.csr_wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_rd_en = 1'b1; bus.csr_rd_addr = a;
    tick();
    bus.csr_rd_en = 1'b0;
    chk(name, bus.csr_rd_data, exp);
  endtask

  // ev = {i_misalign, l_misalign, s_misalign, ecall, ebreak, mret}
  task automatic set_ev(input logic [5:0] ev);
    {bus.i_misalign, bus.l_misalign, bus.s_misalign, bus.ecall, bus.ebreak, bus.mret} = ev;
  endtask

  task automatic pulse(input logic [5:0] ev);
    set_ev(ev);
    tick();
    set_ev(6'b0);
  endtask

  typedef struct {
    logic [5:0]  ev;
    logic [31:0] pc, tgt, maddr, cause, tval;
  } trap_vec_t;

  trap_vec_t tv[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{6'b100000, 32'h60, 32'h2002, 32'h0,    32'd0, 32'h2002};
    tv[1] = '{6'b001000, 32'h64, 32'h0,    32'h3001, 32'd6, 32'h3001};
    tv[2] = '{6'b000010, 32'h58, 32'h0,    32'h0,    32'd3, 32'h58};

    bus.csr_rd_en = 0; bus.csr_rd_addr = 0; bus.csr_wr_en = 0; bus.csr_wr_addr = 0;
    bus.csr_wr_data = 0; bus.pc = 0; bus.pc_addr_in = 0; bus.mem_addr = 0;
    set_ev(6'b0);
    reset = 1'b1;
    #2 reset = 1'b0;
    #30 reset = 1'b1;
    tick();
    chk("reset_delay", {31'b0, bus.csr_delay}, 32'h0);
    chk("reset_pc_csr", bus.pc_csr, 32'h0);
    chk("reset_rd_data", bus.csr_rd_data, 32'h0);
    rd_chk("reset_mstatus", 12'h300, 32'h0000_1800);
    rd_chk("reset_mtvec", 12'h305, 32'h0);
    rd_chk("reset_misa", 12'h301, 32'h4000_0100);

    do_write(12'h305, 32'h0000_0103);
    rd_chk("mtvec_mask", 12'h305, 32'h0000_0100);
    do_write(12'h301, 32'h0);
    rd_chk("misa_ro", 12'h301, 32'h4000_0100);
    do_write(12'h341, 32'h0000_1237);
    rd_chk("mepc_mask", 12'h341, 32'h0000_1234);
    do_write(12'h300, 32'hFFFF_FFFF);
    rd_chk("mstatus_bits", 12'h300, 32'h0000_1888);
    do_write(12'h304, 32'h0000_0888);
    rd_chk("mie_rw", 12'h304, 32'h0000_0888);
    do_write(12'h7C0, 32'h5);
    rd_chk("unimpl_rd", 12'h7C0, 32'h0);
    rd_chk("mip_zero", 12'h344, 32'h0);
    rd_chk("mhartid", 12'hF14, 32'h0);

    // Read and write of the same CSR in one cycle returns the old value
    bus.csr_rd_en = 1; bus.csr_rd_addr = 12'h340;
    do_write(12'h340, 32'hDEAD_BEEF);
    bus.csr_rd_en = 0;
    chk("rdwr_old", bus.csr_rd_data, 32'h0);
    rd_chk("rdwr_new", 12'h340, 32'hDEAD_BEEF);

    // ecall trap
    do_write(12'h305, 32'h80);
    do_write(12'h300, 32'h8);
    bus.pc = 32'h44;
    pulse(6'b000100);
    chk("ecall_delay1", {31'b0, bus.csr_delay}, 32'h1);
    tick();
    chk("ecall_delay2", {31'b0, bus.csr_delay}, 32'h1);
    chk("ecall_pc_csr", bus.pc_csr, 32'h80);
    tick();
    chk("ecall_done", {31'b0, bus.csr_delay}, 32'h0);
    rd_chk("ecall_mepc", 12'h341, 32'h44);
    rd_chk("ecall_mcause", 12'h342, 32'd11);
    rd_chk("ecall_mstatus", 12'h300, 32'h0000_1880);

    // mret
    pulse(6'b000001);
    chk("mret_delay", {31'b0, bus.csr_delay}, 32'h1);
    chk("mret_pc_csr", bus.pc_csr, 32'h44);
    tick();
    chk("mret_done", {31'b0, bus.csr_delay}, 32'h0);
    rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);

    // Priority, and ebreak during SAVE is ignored
    bus.mem_addr = 32'h1003; bus.pc = 32'h4C;
    pulse(6'b010100);
    set_ev(6'b000010);
    tick();
    set_ev(6'b0);
    tick(); tick();
    rd_chk("prio_mcause", 12'h342, 32'd4);
    rd_chk("prio_mtval", 12'h343, 32'h1003);

    for (int i = 0; i < 3; i++) begin
      bus.pc = tv[i].pc; bus.pc_addr_in = tv[i].tgt; bus.mem_addr = tv[i].maddr;
      pulse(tv[i].ev);
      tick(); tick();
      rd_chk("tbl_mcause", 12'h342, tv[i].cause);
      rd_chk("tbl_mtval", 12'h343, tv[i].tval);
    end

    // CSR write to mcause at the end of SAVE loses to the trap update
    pulse(6'b000100);
    do_write(12'h342, 32'h55);
    tick();
    rd_chk("trap_wins", 12'h342, 32'd11);

    // Counter carry
    do_write(12'hB00, 32'hFFFF_FFFF);
    tick(); tick();
    rd_chk("mcycle", 12'hB00, 32'h1);
    rd_chk("mcycleh", 12'hB80, 32'h1);

    // Reset in the middle of a trap
    bus.pc = 32'h90;
    pulse(6'b000100);
    #2 reset = 1'b0;
    #1;
    chk("midrst_delay", {31'b0, bus.csr_delay}, 32'h0);
    chk("midrst_pc_csr", bus.pc_csr, 32'h0);
    #4 reset = 1'b1;
    tick(); tick(); tick();
    rd_chk("midrst_mepc", 12'h341, 32'h0);
    rd_chk("midrst_mcause", 12'h342, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
